// File: rtl/decoder_select_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : decoder_select_scanner
//  Description : Sequential select generator for a 3-to-8 decoder. Walks a
//                3-bit index 0..LAST_INDEX either on a programmable dwell
//                timer (auto-scan) or one position per step pulse (manual),
//                with a valid qualifier and a one-cycle wrap pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module decoder_select_scanner #(
  parameter int DWELL_W    = 16,
  parameter int LAST_INDEX = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               mode,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               step,
  input  logic               hold,
  output logic               a,
  output logic               b,
  output logic               c,
  output logic               sel_valid,
  output logic               wrap
);

  // Out-of-range LAST_INDEX values are pinned into 1..7 so the index can
  // never leave the decoder's 3-bit range.
  localparam int LAST_CLAMP = (LAST_INDEX < 1) ? 1 :
                              ((LAST_INDEX > 7) ? 7 : LAST_INDEX);
  localparam logic [2:0] LAST_IDX = 3'(LAST_CLAMP);

  localparam logic [2:0]         IDX_ZERO = 3'd0;
  localparam logic [2:0]         IDX_ONE  = 3'd1;
  localparam logic [DWELL_W-1:0] CNT_ZERO = '0;
  localparam logic [DWELL_W-1:0] CNT_ONE  = {{(DWELL_W-1){1'b0}}, 1'b1};

  // Scanner states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_AUTO = 2'd1;
  localparam logic [1:0] ST_STEP = 2'd2;

  // Registered state
  logic [1:0]         state;
  logic [2:0]         idx;
  logic [DWELL_W-1:0] cnt;
  logic [DWELL_W-1:0] dwell_lat;

  // Next-state values
  logic [1:0]         state_nxt;
  logic [2:0]         idx_nxt;
  logic [DWELL_W-1:0] cnt_nxt;
  logic [DWELL_W-1:0] dwell_lat_nxt;
  logic               valid_nxt;
  logic               wrap_nxt;
  logic               advance;

  // Next-state decode: en=0 overrides everything, then per-state behaviour,
  // then the shared advance/wrap rule.
  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    cnt_nxt       = cnt;
    dwell_lat_nxt = dwell_lat;
    valid_nxt     = sel_valid;
    wrap_nxt      = 1'b0;
    advance       = 1'b0;

    if (!en) begin
      state_nxt = ST_IDLE;
      idx_nxt   = IDX_ZERO;
      cnt_nxt   = CNT_ZERO;
      valid_nxt = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // Mode is only looked at here; changing it while running has no effect.
          state_nxt     = mode ? ST_STEP : ST_AUTO;
          idx_nxt       = IDX_ZERO;
          cnt_nxt       = CNT_ZERO;
          dwell_lat_nxt = dwell;
          valid_nxt     = 1'b1;
        end
        ST_AUTO: begin
          if (!hold) begin
            if (cnt == dwell_lat) begin
              // Re-latch so a dwell change applies from the next index onward.
              cnt_nxt       = CNT_ZERO;
              dwell_lat_nxt = dwell;
              advance       = 1'b1;
            end else begin
              cnt_nxt = cnt + CNT_ONE;
            end
          end
        end
        ST_STEP: begin
          cnt_nxt = CNT_ZERO;
          if (!hold && step) begin
            advance = 1'b1;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          idx_nxt   = IDX_ZERO;
          cnt_nxt   = CNT_ZERO;
          valid_nxt = 1'b0;
        end
      endcase

      if (advance) begin
        if (idx == LAST_IDX) begin
          idx_nxt  = IDX_ZERO;
          wrap_nxt = 1'b1;
        end else begin
          idx_nxt = idx + IDX_ONE;
        end
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      idx       <= IDX_ZERO;
      cnt       <= CNT_ZERO;
      dwell_lat <= CNT_ZERO;
      sel_valid <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      cnt       <= cnt_nxt;
      dwell_lat <= dwell_lat_nxt;
      sel_valid <= valid_nxt;
      wrap      <= wrap_nxt;
    end
  end

  assign a = idx[0];
  assign b = idx[1];
  assign c = idx[2];

endmodule
`default_nettype wire

// File: tb/tb_decoder_select_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decoder_select_scanner
//  Description : Self-checking bench for decoder_select_scanner. Each scenario
//                queues per-cycle stimulus with the expected post-edge
//                {sel_valid, wrap, c, b, a}, then replays and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_decoder_select_scanner;

  typedef struct packed {
    logic        rst_n;
    logic        en;
    logic        mode;
    logic        step;
    logic        hold;
    logic [15:0] dwell;
  } stim_t;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        mode;
  logic [15:0] dwell;
  logic        step;
  logic        hold;

  logic a7, b7, c7, v7, w7;
  logic a4, b4, c4, v4, w4;

  int errors;
  int checks;

  stim_t      stim_q[$];
  logic [4:0] exp_q[$];

  decoder_select_scanner #(.DWELL_W(16), .LAST_INDEX(7)) dut7 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .dwell(dwell),
    .step(step), .hold(hold), .a(a7), .b(b7), .c(c7),
    .sel_valid(v7), .wrap(w7)
  );

  decoder_select_scanner #(.DWELL_W(16), .LAST_INDEX(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .dwell(dwell),
    .step(step), .hold(hold), .a(a4), .b(b4), .c(c4),
    .sel_valid(v4), .wrap(w4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t mk(logic r, logic e, logic m, logic s, logic h, logic [15:0] d);
    stim_t t;
    t.rst_n = r; t.en = e; t.mode = m; t.step = s; t.hold = h; t.dwell = d;
    return t;
  endfunction

  function void sb_push(stim_t s, logic v, logic w, logic [2:0] i);
    stim_q.push_back(s);
    exp_q.push_back({v, w, i});
  endfunction

  task automatic apply(stim_t s);
    rst_n = s.rst_n; en = s.en; mode = s.mode;
    step = s.step; hold = s.hold; dwell = s.dwell;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    stim_t s;
    logic [4:0] e;
    int n;
    for (int k = 0; k < 2; k++) sb_push(mk(0, 0, 0, 0, 0, 16'd0), 0, 0, 3'd0);
    for (int k = 0; k < 3; k++) sb_push(mk(1, 0, 0, 0, 0, 16'd3), 0, 0, 3'd0);
    n = 0;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      apply(s);
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({v7, w7, c7, b7, a7} !== e) begin
        errors++;
        $display("FAIL reset7 cycle %0d: got %b required %b", n, {v7, w7, c7, b7, a7}, e);
      end
      checks++;
      if ({v4, w4, c4, b4, a4} !== e) begin
        errors++;
        $display("FAIL reset4 cycle %0d: got %b required %b", n, {v4, w4, c4, b4, a4}, e);
      end
      n++;
    end
  endtask

  task automatic test_auto_scan();
    stim_t s, t;
    logic [4:0] e;
    int n;
    sb_push(mk(0, 0, 0, 0, 0, 16'd0), 0, 0, 3'd0);
    s = mk(1, 1, 0, 0, 0, 16'd2);
    for (int k = 0; k < 8; k++)
      for (int r = 0; r < 3; r++) sb_push(s, 1, 0, 3'(k));
    sb_push(s, 1, 1, 3'd0);
    sb_push(s, 1, 0, 3'd0);
    sb_push(s, 1, 0, 3'd0);
    for (int r = 0; r < 3; r++) sb_push(s, 1, 0, 3'd1);
    n = 0;
    while (stim_q.size() > 0) begin
      t = stim_q.pop_front();
      apply(t);
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({v7, w7, c7, b7, a7} !== e) begin
        errors++;
        $display("FAIL auto_scan cycle %0d: got %b required %b", n, {v7, w7, c7, b7, a7}, e);
      end
      n++;
    end
  endtask

  task automatic test_dwell_short();
    stim_t s0, s5, t;
    logic [4:0] e;
    int n;
    sb_push(mk(0, 0, 0, 0, 0, 16'd0), 0, 0, 3'd0);
    s0 = mk(1, 1, 0, 0, 0, 16'd0);
    sb_push(s0, 1, 0, 3'd0);
    sb_push(s0, 1, 0, 3'd1);
    sb_push(s0, 1, 0, 3'd2);
    sb_push(s0, 1, 0, 3'd3);
    sb_push(s0, 1, 0, 3'd4);
    sb_push(s0, 1, 1, 3'd0);
    sb_push(s0, 1, 0, 3'd1);
    sb_push(s0, 1, 0, 3'd2);
    // dwell raised while index 2 is showing: 2 still leaves after one cycle
    s5 = mk(1, 1, 0, 0, 0, 16'd5);
    for (int r = 0; r < 6; r++) sb_push(s5, 1, 0, 3'd3);
    for (int r = 0; r < 6; r++) sb_push(s5, 1, 0, 3'd4);
    sb_push(s5, 1, 1, 3'd0);
    n = 0;
    while (stim_q.size() > 0) begin
      t = stim_q.pop_front();
      apply(t);
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({v4, w4, c4, b4, a4} !== e) begin
        errors++;
        $display("FAIL dwell_short cycle %0d: got %b required %b", n, {v4, w4, c4, b4, a4}, e);
      end
      n++;
    end
  endtask

  task automatic test_hold();
    stim_t s, sh, t;
    logic [4:0] e;
    int n;
    sb_push(mk(0, 0, 0, 0, 0, 16'd0), 0, 0, 3'd0);
    s  = mk(1, 1, 0, 0, 0, 16'd3);
    sh = mk(1, 1, 0, 0, 1, 16'd3);
    for (int k = 0; k < 5; k++)
      for (int r = 0; r < 4; r++) sb_push(s, 1, 0, 3'(k));
    sb_push(s, 1, 0, 3'd5);
    sb_push(s, 1, 0, 3'd5);
    for (int r = 0; r < 10; r++) sb_push(sh, 1, 0, 3'd5);
    sb_push(s, 1, 0, 3'd5);
    sb_push(s, 1, 0, 3'd5);
    for (int r = 0; r < 4; r++) sb_push(s, 1, 0, 3'd6);
    sb_push(s, 1, 0, 3'd7);
    n = 0;
    while (stim_q.size() > 0) begin
      t = stim_q.pop_front();
      apply(t);
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({v7, w7, c7, b7, a7} !== e) begin
        errors++;
        $display("FAIL hold cycle %0d: got %b required %b", n, {v7, w7, c7, b7, a7}, e);
      end
      n++;
    end
  endtask

  task automatic test_manual_step();
    stim_t s_idle, s_step, s_hs, t;
    logic [4:0] e;
    int n;
    sb_push(mk(0, 0, 0, 0, 0, 16'd0), 0, 0, 3'd0);
    s_idle = mk(1, 1, 1, 0, 0, 16'd0);
    s_step = mk(1, 1, 1, 1, 0, 16'd0);
    s_hs   = mk(1, 1, 1, 1, 1, 16'd0);
    for (int r = 0; r < 4; r++) sb_push(s_idle, 1, 0, 3'd0);
    sb_push(s_step, 1, 0, 3'd1);
    sb_push(s_step, 1, 0, 3'd2);
    sb_push(s_step, 1, 0, 3'd3);
    sb_push(s_hs, 1, 0, 3'd3);
    sb_push(s_hs, 1, 0, 3'd3);
    sb_push(s_step, 1, 0, 3'd4);
    sb_push(s_idle, 1, 0, 3'd4);
    sb_push(s_step, 1, 0, 3'd5);
    sb_push(s_idle, 1, 0, 3'd5);
    sb_push(s_step, 1, 0, 3'd6);
    sb_push(s_idle, 1, 0, 3'd6);
    sb_push(s_step, 1, 0, 3'd7);
    sb_push(s_idle, 1, 0, 3'd7);
    sb_push(s_step, 1, 1, 3'd0);
    sb_push(s_idle, 1, 0, 3'd0);
    sb_push(s_step, 1, 0, 3'd1);
    n = 0;
    while (stim_q.size() > 0) begin
      t = stim_q.pop_front();
      apply(t);
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({v7, w7, c7, b7, a7} !== e) begin
        errors++;
        $display("FAIL manual_step cycle %0d: got %b required %b", n, {v7, w7, c7, b7, a7}, e);
      end
      n++;
    end
  endtask

  task automatic test_abort_reset();
    stim_t s_auto, t;
    logic [4:0] e;
    int n;
    sb_push(mk(0, 0, 0, 0, 0, 16'd0), 0, 0, 3'd0);
    s_auto = mk(1, 1, 0, 0, 0, 16'd0);
    for (int k = 0; k < 7; k++) sb_push(s_auto, 1, 0, 3'(k));
    // en dropped at index 6, on the same edge the dwell would expire
    sb_push(mk(1, 0, 0, 0, 0, 16'd0), 0, 0, 3'd0);
    sb_push(mk(1, 1, 1, 0, 0, 16'd0), 1, 0, 3'd0);
    // mode flipped while running must not leave manual stepping
    sb_push(mk(1, 1, 0, 0, 0, 16'd0), 1, 0, 3'd0);
    sb_push(mk(1, 1, 0, 0, 0, 16'd0), 1, 0, 3'd0);
    sb_push(mk(1, 1, 0, 1, 0, 16'd0), 1, 0, 3'd1);
    sb_push(mk(1, 1, 0, 1, 0, 16'd0), 1, 0, 3'd2);
    sb_push(mk(1, 1, 0, 1, 0, 16'd0), 1, 0, 3'd3);
    sb_push(mk(0, 1, 0, 1, 0, 16'd0), 0, 0, 3'd0);
    sb_push(mk(1, 1, 0, 0, 0, 16'd0), 1, 0, 3'd0);
    sb_push(mk(1, 1, 0, 0, 0, 16'd0), 1, 0, 3'd1);
    n = 0;
    while (stim_q.size() > 0) begin
      t = stim_q.pop_front();
      apply(t);
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({v7, w7, c7, b7, a7} !== e) begin
        errors++;
        $display("FAIL abort_reset cycle %0d: got %b required %b", n, {v7, w7, c7, b7, a7}, e);
      end
      n++;
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; dwell = 16'd0; step = 1'b0; hold = 1'b0;
    test_reset();
    test_auto_scan();
    test_dwell_short();
    test_hold();
    test_manual_step();
    test_abort_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
